// File: rtl/branch_pkg.sv
// Shared types for the SIMT branch divergence stack: the branch class
// reported on diverging and the layout of one stack entry.
package branch_pkg;

  localparam int BR_SP_PER_MP = 8;
  localparam int BR_PC_WIDTH  = 32;

  typedef enum logic [1:0] {
    DIV_SPLIT = 2'd0,
    DIV_NONE  = 2'd1,
    DIV_ALL   = 2'd2,
    DIV_IDLE  = 2'd3
  } div_class_t;

  // phase 0: taken path running, not-taken path still pending.
  // phase 1: not-taken path running, original mask restored at reconvergence.
  typedef struct packed {
    logic [BR_PC_WIDTH-1:0]  pc;
    logic [BR_SP_PER_MP-1:0] nt_mask;
    logic [BR_PC_WIDTH-1:0]  rpc;
    logic [BR_SP_PER_MP-1:0] orig_mask;
    logic                    phase;
  } stack_entry_t;

endpackage

// File: rtl/branch_stack_if.sv
// Fetch/issue side bundle of the branch stack: warp init, resolved branches,
// reconvergence probes in; mask, redirect and status out.
interface branch_stack_if
  import branch_pkg::*;
#(
  parameter int SP_PER_MP   = BR_SP_PER_MP,
  parameter int PC_WIDTH    = BR_PC_WIDTH,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                 init_valid;
  logic [SP_PER_MP-1:0] init_mask;
  logic                 branch_valid;
  logic [SP_PER_MP-1:0] taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  fallthrough_pc;
  logic [PC_WIDTH-1:0]  reconv_pc;
  logic                 reconv_valid;
  logic [PC_WIDTH-1:0]  reconv_check_pc;

  logic [SP_PER_MP-1:0] active_mask;
  logic                 redirect_valid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic [1:0]           diverging;
  logic                 stack_empty;
  logic                 stack_full;
  logic [DW-1:0]        depth;
  logic                 overflow_err;
  logic                 protocol_err;

  modport master (
    output init_valid, init_mask, branch_valid, taken, branch_target,
           fallthrough_pc, reconv_pc, reconv_valid, reconv_check_pc,
    input  active_mask, redirect_valid, redirect_pc, diverging,
           stack_empty, stack_full, depth, overflow_err, protocol_err
  );

  modport slave (
    input  init_valid, init_mask, branch_valid, taken, branch_target,
           fallthrough_pc, reconv_pc, reconv_valid, reconv_check_pc,
    output active_mask, redirect_valid, redirect_pc, diverging,
           stack_empty, stack_full, depth, overflow_err, protocol_err
  );

endinterface

// File: rtl/branch_mask_split.sv
// Splits the active mask by per-SP branch outcome and classifies the branch
// (divergent / none taken / all taken / no active SP).
module branch_mask_split
  import branch_pkg::*;
#(
  parameter int SP_PER_MP = BR_SP_PER_MP
) (
  input  logic [SP_PER_MP-1:0] active_mask,
  input  logic [SP_PER_MP-1:0] taken,
  output logic [SP_PER_MP-1:0] tk,
  output logic [SP_PER_MP-1:0] nt,
  output div_class_t           br_class
);

  always_comb begin
    tk = active_mask & taken;
    nt = active_mask & ~taken;
    if (active_mask == '0)
      br_class = DIV_IDLE;
    else if (nt == '0)
      br_class = DIV_ALL;
    else if (tk == '0)
      br_class = DIV_NONE;
    else
      br_class = DIV_SPLIT;
  end

endmodule

// File: rtl/branch_stack.sv
// Per-warp SIMT divergence stack: pushes on divergent branches, runs the
// taken path, then the not-taken path, then restores the mask at reconvergence.
module branch_stack
  import branch_pkg::*;
#(
  parameter int SP_PER_MP   = BR_SP_PER_MP,
  parameter int STACK_DEPTH = 4,
  parameter int PC_WIDTH    = BR_PC_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  branch_stack_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Entries use the package widths; PC_WIDTH/SP_PER_MP must not exceed them.
  stack_entry_t         stack_q [STACK_DEPTH];
  logic [DW-1:0]        depth_q, depth_d;
  logic [SP_PER_MP-1:0] mask_q, mask_d;
  logic                 redir_q, redir_d;
  logic [PC_WIDTH-1:0]  redir_pc_q, redir_pc_d;
  div_class_t           div_q, div_d;
  logic                 empty_q, full_q;
  logic                 ovf_q, ovf_d;
  logic                 proto_q, proto_d;

  logic [SP_PER_MP-1:0] tk, nt;
  div_class_t           br_class;
  logic                 do_branch, do_reconv, reconv_hit, full_now;
  logic                 push, set_phase;
  logic [IW-1:0]        top_idx, push_idx;
  stack_entry_t         top_entry, new_entry;

  branch_mask_split #(.SP_PER_MP(SP_PER_MP)) u_split (
    .active_mask (mask_q),
    .taken       (bus.taken),
    .tk          (tk),
    .nt          (nt),
    .br_class    (br_class)
  );

  // Arbitration (init > branch > reconv) and the next-state decision.
  always_comb begin
    do_branch  = bus.branch_valid && !bus.init_valid;
    do_reconv  = bus.reconv_valid && !bus.init_valid && !bus.branch_valid;
    top_idx    = IW'(depth_q - 1'b1);
    push_idx   = IW'(depth_q);
    top_entry  = stack_q[top_idx];
    full_now   = (depth_q == DW'(STACK_DEPTH));
    reconv_hit = do_reconv && (depth_q != '0) &&
                 (top_entry.rpc == BR_PC_WIDTH'(bus.reconv_check_pc));
    new_entry  = '{pc:        BR_PC_WIDTH'(bus.fallthrough_pc),
                   nt_mask:   BR_SP_PER_MP'(nt),
                   rpc:       BR_PC_WIDTH'(bus.reconv_pc),
                   orig_mask: BR_SP_PER_MP'(mask_q),
                   phase:     1'b0};

    mask_d     = mask_q;
    depth_d    = depth_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    div_d      = div_q;
    ovf_d      = ovf_q;
    proto_d    = proto_q ||
                 ((32'(bus.init_valid) + 32'(bus.branch_valid) + 32'(bus.reconv_valid)) > 32'd1);
    push       = 1'b0;
    set_phase  = 1'b0;

    if (bus.init_valid) begin
      mask_d  = bus.init_mask;
      depth_d = '0;
    end else if (do_branch) begin
      div_d = br_class;
      case (br_class)
        DIV_ALL: begin
          redir_d    = 1'b1;
          redir_pc_d = bus.branch_target;
        end
        DIV_SPLIT: begin
          if (full_now) begin
            ovf_d = 1'b1;
          end else begin
            push       = 1'b1;
            mask_d     = tk;
            depth_d    = depth_q + 1'b1;
            redir_d    = 1'b1;
            redir_pc_d = bus.branch_target;
          end
        end
        default: ;
      endcase
    end else if (reconv_hit) begin
      if (!top_entry.phase) begin
        mask_d     = SP_PER_MP'(top_entry.nt_mask);
        redir_d    = 1'b1;
        redir_pc_d = PC_WIDTH'(top_entry.pc);
        set_phase  = 1'b1;
      end else begin
        mask_d  = SP_PER_MP'(top_entry.orig_mask);
        depth_d = depth_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '1;
      depth_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      div_q      <= DIV_NONE;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      depth_q    <= depth_d;
      empty_q    <= (depth_d == '0);
      full_q     <= (depth_d == DW'(STACK_DEPTH));
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      div_q      <= div_d;
      ovf_q      <= ovf_d;
      proto_q    <= proto_d;
    end
  end

  // Entry storage needs no reset; depth alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push)
        stack_q[push_idx] <= new_entry;
      if (set_phase)
        stack_q[top_idx].phase <= 1'b1;
    end
  end

  assign bus.active_mask    = mask_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.diverging      = div_q;
  assign bus.stack_empty    = empty_q;
  assign bus.stack_full     = full_q;
  assign bus.depth          = depth_q;
  assign bus.overflow_err   = ovf_q;
  assign bus.protocol_err   = proto_q;

endmodule

// File: tb/tb_branch_stack.sv
// Bench for branch_stack: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the stack rules.
module tb_branch_stack;
  import branch_pkg::*;

  localparam int SPN = 8;
  localparam int PCW = 32;
  localparam int SD  = 4;
  localparam int DW  = $clog2(SD + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_stack_if #(.SP_PER_MP(SPN), .PC_WIDTH(PCW), .STACK_DEPTH(SD)) bus ();

  branch_stack #(.SP_PER_MP(SPN), .STACK_DEPTH(SD), .PC_WIDTH(PCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PCW-1:0] pc;
    logic [SPN-1:0] nt;
    logic [PCW-1:0] rpc;
    logic [SPN-1:0] orig;
    bit             second;
  } m_entry_t;

  m_entry_t       mstack[$];
  logic [SPN-1:0] m_mask;
  bit             m_redir;
  logic [PCW-1:0] m_redir_pc;
  int             m_div;
  bit             m_ovf, m_proto;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit iv, input logic [SPN-1:0] im,
                           input bit bv, input logic [SPN-1:0] tkn,
                           input logic [PCW-1:0] tgt, input logic [PCW-1:0] fall,
                           input logic [PCW-1:0] rpc, input bit rv,
                           input logic [PCW-1:0] cpc);
    logic [SPN-1:0] t, n;
    m_entry_t e;
    if (r) begin
      m_mask = '1; mstack.delete(); m_redir = 0; m_redir_pc = '0;
      m_div = 1; m_ovf = 0; m_proto = 0;
      return;
    end
    m_redir = 0;
    if (int'(iv) + int'(bv) + int'(rv) > 1) m_proto = 1;
    if (iv) begin
      m_mask = im;
      mstack.delete();
    end else if (bv) begin
      t = m_mask & tkn;
      n = m_mask & ~tkn;
      if (m_mask == 0)      m_div = 3;
      else if (n == 0)      m_div = 2;
      else if (t == 0)      m_div = 1;
      else                  m_div = 0;
      if (m_div == 2) begin
        m_redir = 1; m_redir_pc = tgt;
      end else if (m_div == 0) begin
        if (mstack.size() == SD) m_ovf = 1;
        else begin
          e = '{pc: fall, nt: n, rpc: rpc, orig: m_mask, second: 0};
          mstack.push_back(e);
          m_mask = t; m_redir = 1; m_redir_pc = tgt;
        end
      end
    end else if (rv && mstack.size() > 0 && mstack[mstack.size()-1].rpc == cpc) begin
      e = mstack[mstack.size()-1];
      if (!e.second) begin
        m_mask = e.nt; m_redir = 1; m_redir_pc = e.pc;
        e.second = 1;
        mstack[mstack.size()-1] = e;
      end else begin
        m_mask = e.orig;
        void'(mstack.pop_back());
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".mask"},  64'(bus.active_mask), 64'(m_mask));
    checkOutput({tag, ".redir"}, 64'(bus.redirect_valid), 64'(m_redir));
    if (m_redir)
      checkOutput({tag, ".rpc"}, 64'(bus.redirect_pc), 64'(m_redir_pc));
    checkOutput({tag, ".div"},   64'(bus.diverging), 64'(m_div));
    checkOutput({tag, ".depth"}, 64'(bus.depth), 64'(mstack.size()));
    checkOutput({tag, ".empty"}, 64'(bus.stack_empty), 64'(mstack.size() == 0));
    checkOutput({tag, ".full"},  64'(bus.stack_full), 64'(mstack.size() == SD));
    checkOutput({tag, ".ovf"},   64'(bus.overflow_err), 64'(m_ovf));
    checkOutput({tag, ".proto"}, 64'(bus.protocol_err), 64'(m_proto));
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit iv,
                               input logic [SPN-1:0] im, input bit bv,
                               input logic [SPN-1:0] tkn, input logic [PCW-1:0] tgt,
                               input logic [PCW-1:0] fall, input logic [PCW-1:0] rpc,
                               input bit rv, input logic [PCW-1:0] cpc);
    rst                 = r;
    bus.init_valid      = iv;
    bus.init_mask       = im;
    bus.branch_valid    = bv;
    bus.taken           = tkn;
    bus.branch_target   = tgt;
    bus.fallthrough_pc  = fall;
    bus.reconv_pc       = rpc;
    bus.reconv_valid    = rv;
    bus.reconv_check_pc = cpc;
    @(posedge clk);
    modelStep(r, iv, im, bv, tkn, tgt, fall, rpc, rv, cpc);
    #1;
    compareAll(tag);
  endtask

  task automatic doReset();
    applyStimulus("rst", 1, 0, '0, 0, '0, '0, '0, '0, 0, '0);
  endtask
  task automatic doInit(input logic [SPN-1:0] im);
    applyStimulus("init", 0, 1, im, 0, '0, '0, '0, '0, 0, '0);
  endtask
  task automatic doBranch(input string tag, input logic [SPN-1:0] tkn,
                          input logic [PCW-1:0] tgt, input logic [PCW-1:0] fall,
                          input logic [PCW-1:0] rpc);
    applyStimulus(tag, 0, 0, '0, 1, tkn, tgt, fall, rpc, 0, '0);
  endtask
  task automatic doReconv(input string tag, input logic [PCW-1:0] cpc);
    applyStimulus(tag, 0, 0, '0, 0, '0, '0, '0, '0, 1, cpc);
  endtask
  task automatic doIdle(input string tag);
    applyStimulus(tag, 0, 0, '0, 0, '0, '0, '0, '0, 0, '0);
  endtask

  initial begin
    logic [SPN-1:0] nest_tk [5];
    nest_tk = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07};

    doReset();
    checkOutput("reset_mask", 64'(bus.active_mask), 64'hFF);
    checkOutput("reset_div", 64'(bus.diverging), 64'd1);
    checkOutput("reset_rpc", 64'(bus.redirect_pc), 64'd0);

    // Basic divergence and two-step reconvergence
    doInit(8'hFF);
    doBranch("div", 8'h0F, 32'h40, 32'h20, 32'h80);
    checkOutput("div_mask", 64'(bus.active_mask), 64'h0F);
    checkOutput("div_rpc", 64'(bus.redirect_pc), 64'h40);
    checkOutput("div_depth", 64'(bus.depth), 64'd1);
    doReconv("rc0", 32'h80);
    checkOutput("rc0_mask", 64'(bus.active_mask), 64'hF0);
    checkOutput("rc0_rpc", 64'(bus.redirect_pc), 64'h20);
    doReconv("rc_miss", 32'h84);
    doReconv("rc1", 32'h80);
    checkOutput("rc1_mask", 64'(bus.active_mask), 64'hFF);
    checkOutput("rc1_redir", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rc1_depth", 64'(bus.depth), 64'd0);
    doReconv("rc_empty", 32'h80);

    // Uniform branches
    doInit(8'h0F);
    doBranch("none", 8'hF0, 32'h100, 32'h104, 32'h200);
    checkOutput("none_div", 64'(bus.diverging), 64'd1);
    checkOutput("none_redir", 64'(bus.redirect_valid), 64'd0);
    doBranch("all", 8'hFF, 32'h300, 32'h304, 32'h400);
    checkOutput("all_div", 64'(bus.diverging), 64'd2);
    checkOutput("all_rpc", 64'(bus.redirect_pc), 64'h300);
    checkOutput("all_mask", 64'(bus.active_mask), 64'h0F);
    doInit(8'h00);
    doBranch("idle", 8'hFF, 32'h500, 32'h504, 32'h600);
    checkOutput("idle_div", 64'(bus.diverging), 64'd3);

    // Nesting past capacity
    doInit(8'hFF);
    for (int i = 0; i < 5; i++)
      doBranch("nest", nest_tk[i], 32'(32'h1000 + i * 16), 32'(32'h2000 + i * 16),
               32'(32'h3000 + i * 16));
    checkOutput("nest_depth", 64'(bus.depth), 64'd4);
    checkOutput("nest_full", 64'(bus.stack_full), 64'd1);
    checkOutput("nest_mask", 64'(bus.active_mask), 64'h0F);
    checkOutput("nest_ovf", 64'(bus.overflow_err), 64'd1);
    doReconv("nest_rc", 32'h3030);
    doInit(8'hFF);
    checkOutput("ovf_sticky", 64'(bus.overflow_err), 64'd1);

    // Conflicting valids, then reset mid-divergence
    applyStimulus("conflict", 0, 0, '0, 1, 8'h0F, 32'h40, 32'h20, 32'h80, 1, 32'h80);
    checkOutput("conflict_depth", 64'(bus.depth), 64'd1);
    checkOutput("conflict_proto", 64'(bus.protocol_err), 64'd1);
    doBranch("d2", 8'h03, 32'h50, 32'h60, 32'h70);
    doReset();
    checkOutput("rst2_depth", 64'(bus.depth), 64'd0);
    checkOutput("rst2_proto", 64'(bus.protocol_err), 64'd0);
    checkOutput("rst2_ovf", 64'(bus.overflow_err), 64'd0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      logic [PCW-1:0] cpc;
      op = int'($urandom_range(0, 99));
      if (op < 2) doReset();
      else if (op < 8) doInit((($urandom_range(0, 9)) == 0) ? 8'h00 : 8'($urandom));
      else if (op < 48) begin
        logic [SPN-1:0] tkn;
        case ($urandom_range(0, 5))
          0: tkn = '0;
          1: tkn = '1;
          default: tkn = 8'($urandom);
        endcase
        doBranch("rnd_br", tkn, 32'($urandom_range(0, 255)) << 2,
                 32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2);
      end else if (op < 90) begin
        if (mstack.size() > 0 && $urandom_range(0, 3) != 0) cpc = mstack[mstack.size()-1].rpc;
        else cpc = 32'($urandom_range(0, 255)) << 2;
        doReconv("rnd_rc", cpc);
      end else if (op < 95) begin
        cpc = (mstack.size() > 0) ? mstack[mstack.size()-1].rpc : 32'h0;
        applyStimulus("rnd_multi", 0, 1'($urandom), 8'($urandom), 1'($urandom),
                      8'($urandom), 32'h44, 32'h48, 32'h4C, 1, cpc);
      end else doIdle("rnd_idle");
    end

    doIdle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_stack.md
BRANCH_STACK -- requirements
Module: branch_stack

Interface
REQ-001 Parameter SP_PER_MP, default 8, number of SPs (threads) per MP.
REQ-002 Parameter STACK_DEPTH, default 4, maximum nested divergent branches.
REQ-003 Parameter PC_WIDTH, default 32, program counter width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 init_valid  input  1  warp start; loads init_mask, clears stack.
REQ-008 init_mask  input  SP_PER_MP  initial active mask.
REQ-009 branch_valid  input  1  branch instruction resolved this cycle.
REQ-010 taken  input  SP_PER_MP  per-SP branch outcome.
REQ-011 branch_target  input  PC_WIDTH  taken-path PC.
REQ-012 fallthrough_pc  input  PC_WIDTH  not-taken-path PC.
REQ-013 reconv_pc  input  PC_WIDTH  reconvergence PC of this branch.
REQ-014 reconv_valid  input  1  instruction at reconv_check_pc about to issue.
REQ-015 reconv_check_pc  input  PC_WIDTH  PC compared against top-of-stack reconvergence PC.
REQ-016 active_mask  output  SP_PER_MP  current enabled SPs, registered.
REQ-017 redirect_valid  output  1  one-cycle pulse, fetch must jump.
REQ-018 redirect_pc  output  PC_WIDTH  jump target, valid with redirect_valid.
REQ-019 diverging  output  2  registered branch class: 0 divergent, 1 none taken, 2 all taken, 3 no active SP.
REQ-020 stack_empty, stack_full  output  1 each  stack occupancy flags.
REQ-021 depth  output  clog2(STACK_DEPTH+1)  occupied entries.
REQ-022 overflow_err  output  1  sticky; divergent branch with stack full.
REQ-023 protocol_err  output  1  sticky; more than one of init/branch/reconv valid in one cycle.

Function
REQ-024 Classification SHALL use the active mask: tk = active_mask & taken, nt = active_mask & ~taken; class 3 if active_mask==0, 2 if nt==0, 1 if tk==0, else 0.
REQ-025 All outputs SHALL be registered; effect of any valid input is visible the following cycle (latency 1).
REQ-026 Stack entry SHALL hold {pc, nt_mask, rpc, orig_mask, phase}.
REQ-027 Branch class 2: redirect to branch_target; mask unchanged; stack unchanged.
REQ-028 Branch class 1 or 3: no redirect; mask and stack unchanged.
REQ-029 Branch class 0, stack not full: push {fallthrough_pc, nt, reconv_pc, active_mask, phase=0}; active_mask<=tk; redirect to branch_target.
REQ-030 Branch class 0, stack full: no push, no redirect, mask unchanged, overflow_err<=1.
REQ-031 Reconv hit (reconv_valid, stack not empty, reconv_check_pc==top.rpc), phase 0: active_mask<=top.nt_mask; redirect to top.pc; top.phase<=1; depth unchanged.
REQ-032 Reconv hit, phase 1: active_mask<=top.orig_mask; pop; no redirect.
REQ-033 Reconv with stack empty or PC mismatch: no effect.
REQ-034 Only the top entry is compared; nested reconvergence resolves innermost first.
REQ-035 init_valid: active_mask<=init_mask; depth<=0; no redirect; errors unchanged.
REQ-036 Simultaneous valids: priority init > branch > reconv; lower ones ignored; protocol_err<=1.
REQ-037 redirect_valid SHALL be low in every cycle not caused by REQ-027/029/031.
REQ-038 stack_full SHALL equal depth==STACK_DEPTH; stack_empty SHALL equal depth==0.

Reset
REQ-039 On rst: active_mask all ones, depth 0, stack_empty 1, stack_full 0, redirect_valid 0, redirect_pc 0, diverging 1, both error flags 0.
REQ-040 rst SHALL override all other inputs in the same cycle, including mid-divergence; stack contents need no clearing.

Structure
REQ-041 Package branch_pkg SHALL hold the diverging class enum and the stack entry struct type, parameterised via PC_WIDTH/SP_PER_MP localparams.
REQ-042 Sub-module branch_mask_split (combinational tk/nt/class from active_mask and taken) SHALL be instantiated once.

Verification
REQ-043 rst, init 8'hFF; branch taken=8'h0F, target 0x40, fall 0x20, rpc 0x80 -> mask 8'h0F, redirect 0x40, diverging 0, depth 1.
REQ-044 Continue: reconv 0x80 -> mask 8'hF0, redirect 0x20; reconv 0x80 again -> mask 8'hFF, no redirect, depth 0.
REQ-045 Mask 8'h0F, taken=8'hF0 -> diverging 1, no redirect; taken=8'hFF -> diverging 2, redirect to target, mask 8'h0F.
REQ-046 Five nested divergent branches with STACK_DEPTH 4 -> depth 4, stack_full 1, fifth ignored, overflow_err 1 until rst.
REQ-047 branch_valid and reconv_valid together -> branch only executed, protocol_err 1; rst at depth 2 -> all REQ-039 values next cycle.
